mem_stage: RTL and testbench

Byte-serial memory-access (MEM) stage of the five-stage RISC-V pipeline, between the EX/MEM pipeline register and the MEM/WB register. Non-memory instructions pass through combinationally. Loads and stores are sequenced one byte per cycle over an 8-bit synchronous RAM port, with `stallreq` held to the pipeline control module until the access completes. Load results are sign- or zero-extended to 32 bits before they reach MEM/WB.

---
 rtl/mem_stage.sv | 93 +++++++++
 tb/tb_mem_stage.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: byte-serial MEM stage; loads/stores sequenced one byte per cycle over an 8-bit RAM port.
// Optional MEM_LOAD_FAST_EN: skip WAIT and merge the final load byte combinationally in DONE.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wAddr,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wData,
  input  logic [3:0]  ex_memOp,
  input  logic [31:0] ex_memAddr,
  input  logic [31:0] ex_storeData,
  input  logic [7:0]  ram_rdata,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        stallreq,
  output logic [4:0]  mem_wAddr,
  output logic        mem_wreg,
  output logic [31:0] mem_wData
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3;
`ifdef MEM_LOAD_FAST_EN
  localparam logic [1:0] LOAD_END = DONE;
`else
  localparam logic [1:0] LOAD_END = WAIT;
`endif
  logic [1:0]  state_q, state_d, cnt_q, cnt_d, idx_q, idx_d;
  logic [3:0]  op_q, op_d;
  logic        pend_q, pend_d;
  logic [31:0] res_q, res_d;
  logic [31:0] res_m, fin, ext;
  logic [3:0]  op;
  logic [1:0]  nm1, byte_sel;
  logic        ex_mem, st, last, req;
  always_comb begin
    ex_mem   = (ex_memOp >= 4'd1) && (ex_memOp <= 4'd8);
    op       = (state_q == IDLE) ? ex_memOp : op_q;
    st       = op >= 4'd6;
    nm1      = (op == 4'd3 || op == 4'd8) ? 2'd3 : (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2'd1 : 2'd0;
    byte_sel = (state_q == IDLE) ? 2'd0 : cnt_q;
    last     = byte_sel == nm1;
    req      = (state_q == IDLE && ex_mem) || state_q == ACCESS;
    res_m    = res_q;
    res_m[{idx_q, 3'b000} +: 8] = ram_rdata;
    res_d    = pend_q ? res_m : res_q;
    pend_d   = req && !st;
    idx_d    = byte_sel;
    op_d     = (state_q == IDLE) ? ex_memOp : op_q;
    state_d  = (state_q == IDLE)   ? (ex_mem ? (last ? (st ? DONE : LOAD_END) : ACCESS) : IDLE) :
               (state_q == ACCESS) ? (last ? (st ? DONE : LOAD_END) : ACCESS) :
               (state_q == WAIT)   ? DONE : IDLE;
    cnt_d    = (state_d == ACCESS) ? byte_sel + 2'd1 : 2'd0;
`ifdef MEM_LOAD_FAST_EN
    fin      = pend_q ? res_m : res_q;
`else
    fin      = res_q;
`endif
    ext      = (op_q == 4'd1) ? {{24{fin[7]}}, fin[7:0]} :
               (op_q == 4'd2) ? {{16{fin[15]}}, fin[15:0]} :
               (op_q == 4'd3) ? fin :
               (op_q == 4'd4) ? {24'b0, fin[7:0]} :
               (op_q == 4'd5) ? {16'b0, fin[15:0]} : ex_wData;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      op_q    <= 4'd0;
      pend_q  <= 1'b0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      res_q   <= res_d;
    end
  end
  // While a memory op is in flight the stage presents a non-writing bubble.
  always_comb begin
    ram_ce    = !rst && req;
    ram_we    = ram_ce && st;
    ram_addr  = ram_ce ? ex_memAddr + {30'b0, byte_sel} : 32'd0;
    ram_wdata = ram_we ? ex_storeData[{byte_sel, 3'b000} +: 8] : 8'd0;
    stallreq  = !rst && (req || state_q == WAIT);
    mem_wAddr = rst ? 5'd0 : ex_wAddr;
    mem_wreg  = rst ? 1'b0 : (state_q == DONE || (state_q == IDLE && !ex_mem)) ? ex_wreg : 1'b0;
    mem_wData = rst ? 32'd0 : (state_q == DONE) ? ext : (state_q == IDLE && !ex_mem) ? ex_wData : 32'd0;
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage with a byte RAM model.
module tb_mem_stage;
  logic        clk = 0, rst = 1;
  logic [4:0]  ex_wAddr = 0;
  logic        ex_wreg = 0;
  logic [31:0] ex_wData = 0, ex_memAddr = 0, ex_storeData = 0;
  logic [3:0]  ex_memOp = 0;
  logic [7:0]  ram_rdata = 0;
  logic        ram_ce, ram_we, stallreq, mem_wreg;
  logic [31:0] ram_addr, mem_wData;
  logic [7:0]  ram_wdata;
  logic [4:0]  mem_wAddr;
  int n_chk = 0, n_fail = 0;
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] rq [$];
  logic [39:0] wq [$];
`ifdef MEM_LOAD_FAST_EN
  localparam int LX = 0;
`else
  localparam int LX = 1;
`endif
  mem_stage dut (
    .clk(clk), .rst(rst), .ex_wAddr(ex_wAddr), .ex_wreg(ex_wreg), .ex_wData(ex_wData),
    .ex_memOp(ex_memOp), .ex_memAddr(ex_memAddr), .ex_storeData(ex_storeData),
    .ram_rdata(ram_rdata), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .stallreq(stallreq), .mem_wAddr(mem_wAddr), .mem_wreg(mem_wreg),
    .mem_wData(mem_wData)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      n_chk++;
      assert (wq.size() > 0 && wq[0] === {ram_addr, ram_wdata}) else begin
        n_fail++;
        $error("FAIL ram_write got %h exp %h", {ram_addr, ram_wdata}, wq.size() > 0 ? wq[0] : 40'h0);
      end
      if (wq.size() > 0) void'(wq.pop_front());
      mem[ram_addr] = ram_wdata;
    end else if (ram_ce) begin
      n_chk++;
      assert (rq.size() > 0 && rq[0] === ram_addr) else begin
        n_fail++;
        $error("FAIL ram_read got %h exp %h", ram_addr, rq.size() > 0 ? rq[0] : 32'h0);
      end
      if (rq.size() > 0) void'(rq.pop_front());
      ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;
    end
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s got %h exp %h", tag, o, e);
    end
  endtask
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, sd, wd,
                     input int exp_st, input logic [31:0] exp_d);
    int k;
    @(negedge clk);
    ex_memOp = op; ex_memAddr = a; ex_storeData = sd; ex_wData = wd; ex_wAddr = 5'd7; ex_wreg = 1;
    #1;
    k = 0;
    while (stallreq && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk({tag, "_stall"}, k, exp_st);
    chk({tag, "_data"}, mem_wData, exp_d);
    chk({tag, "_wreg"}, {31'b0, mem_wreg}, 32'd1);
    chk({tag, "_waddr"}, {27'b0, mem_wAddr}, 32'd7);
  endtask
  task automatic bubble();
    @(negedge clk);
    ex_memOp = 0; ex_wreg = 0; ex_wData = 0;
  endtask
  initial begin
    mem[32'h100] = 8'hEF; mem[32'h101] = 8'hBE; mem[32'h102] = 8'hAD; mem[32'h103] = 8'hDE;
    mem[32'h20] = 8'h80; mem[32'h3] = 8'h00; mem[32'h4] = 8'h80;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'b0, stallreq}, 0);
    chk("rst_ce", {31'b0, ram_ce}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", mem_wData, 0);
    chk("rst_waddr", {27'b0, mem_wAddr}, 0);
    chk("rst_wreg", {31'b0, mem_wreg}, 0);
    @(negedge clk);
    rst = 0;
    ex_memOp = 0; ex_wData = 32'h12345678; ex_wAddr = 5'd5; ex_wreg = 1;
    #1;
    chk("pt_data", mem_wData, 32'h12345678);
    chk("pt_waddr", {27'b0, mem_wAddr}, 5);
    chk("pt_wreg", {31'b0, mem_wreg}, 1);
    chk("pt_stall", {31'b0, stallreq}, 0);
    chk("pt_ce", {31'b0, ram_ce}, 0);
    for (int i = 0; i < 4; i++) rq.push_back(32'h100 + i);
    run("lw", 4'd3, 32'h100, 0, 32'h55, 4 + LX, 32'hDEADBEEF);
    rq.push_back(32'h20);
    run("lb", 4'd1, 32'h20, 0, 32'h55, 1 + LX, 32'hFFFFFF80);
    rq.push_back(32'h20);
    run("lbu", 4'd4, 32'h20, 0, 32'h55, 1 + LX, 32'h00000080);
    rq.push_back(32'h3); rq.push_back(32'h4);
    run("lh", 4'd2, 32'h3, 0, 32'h55, 2 + LX, 32'hFFFF8000);
    rq.push_back(32'h3); rq.push_back(32'h4);
    run("lhu", 4'd5, 32'h3, 0, 32'h55, 2 + LX, 32'h00008000);
    wq.push_back({32'hFFFFFFFF, 8'hDD}); wq.push_back({32'h0, 8'hCC});
    run("sh", 4'd7, 32'hFFFFFFFF, 32'hAABBCCDD, 32'hCAFE, 2, 32'hCAFE);
    for (int i = 0; i < 4; i++) wq.push_back({32'h300 + i, 8'(32'h11223344 >> (8 * i))});
    run("sw", 4'd8, 32'h300, 32'h11223344, 32'hBEEF, 4, 32'hBEEF);
    for (int i = 0; i < 4; i++) rq.push_back(32'h300 + i);
    run("lw2", 4'd3, 32'h300, 0, 32'h55, 4 + LX, 32'h11223344);
    bubble();
    @(negedge clk);
    ex_memOp = 4'd3; ex_memAddr = 32'h200; ex_wreg = 1; ex_wAddr = 5'd9;
    rq.push_back(32'h200);
    #1;
    chk("rl_stall0", {31'b0, stallreq}, 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rl_stall", {31'b0, stallreq}, 0);
    chk("rl_ce", {31'b0, ram_ce}, 0);
    chk("rl_addr", ram_addr, 0);
    chk("rl_data", mem_wData, 0);
    chk("rl_waddr", {27'b0, mem_wAddr}, 0);
    @(negedge clk);
    ex_memOp = 0; ex_wreg = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rl_idle", {31'b0, stallreq}, 0);
    rq.push_back(32'h100);
    run("lbu2", 4'd4, 32'h100, 0, 32'h55, 1 + LX, 32'h000000EF);
    bubble();
    repeat (3) @(negedge clk);
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
